// File: rtl/button_input.sv
// -----------------------------------------------------------------------------
// button_input
// Four push-button inputs. Each raw pin is synchronized, debounced, and on a
// debounced press (0->1) records a bit in a press latch. The latch is read over
// a shared 4-bit tri-state data bus and cleared when the read finishes.
//
// Parameters
//   DEBOUNCE_CYCLES : consecutive mismatching samples needed to commit a new
//                     debounced level (1..255)
// Ports
//   clk         : system clock, rising edge
//   reset       : synchronous, active-high reset
//   PUSHBUTTONS : raw button pins, 1 = pressed, asynchronous to clk
//   oeIN        : output enable from the address decoder, 1 = drive the bus
//   data_bus    : press latch while oeIN=1, high impedance otherwise
//   BTN_LEVEL   : debounced button levels
//   PENDING     : OR of the press-latch bits
// -----------------------------------------------------------------------------
module button_input #(
   parameter int unsigned DEBOUNCE_CYCLES = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] PUSHBUTTONS,
   input  logic       oeIN,
   output logic [3:0] data_bus,
   output logic [3:0] BTN_LEVEL,
   output logic       PENDING
);

   // Counter value on which the next mismatching sample commits the new level.
   localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

   logic [3:0] sync1_r;
   logic [3:0] sync2_r;
   logic [3:0] stable_r;
   logic [3:0] latch_r;
   logic       oein_d_r;
   logic [7:0] cnt_r [4];

   logic [3:0] stable_nxt_s;
   logic [7:0] cnt_nxt_s [4];
   logic [3:0] rise_s;
   logic       rd_done_s;
   logic [3:0] latch_nxt_s;

   // Per-bit debounce: a match clears the count, the last mismatch commits.
   always_comb begin
      stable_nxt_s = stable_r;
      for (int i = 0; i < 4; i++) begin
         cnt_nxt_s[i] = cnt_r[i];
         if (sync2_r[i] == stable_r[i]) begin
            cnt_nxt_s[i] = 8'd0;
         end else if (cnt_r[i] == CNT_LAST) begin
            stable_nxt_s[i] = sync2_r[i];
            cnt_nxt_s[i]    = 8'd0;
         end else begin
            cnt_nxt_s[i] = cnt_r[i] + 8'd1;
         end
      end
   end

   // Press latch: a read finishes when oeIN falls; a new press on that same
   // edge survives because the set is OR-ed in after the clear.
   always_comb begin
      rise_s      = stable_nxt_s & ~stable_r;
      rd_done_s   = oein_d_r & ~oeIN;
      latch_nxt_s = (rd_done_s ? 4'b0000 : latch_r) | rise_s;
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_r  <= 4'b0000;
         sync2_r  <= 4'b0000;
         stable_r <= 4'b0000;
         latch_r  <= 4'b0000;
         oein_d_r <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            cnt_r[i] <= 8'd0;
         end
      end else begin
         sync1_r  <= PUSHBUTTONS;
         sync2_r  <= sync1_r;
         stable_r <= stable_nxt_s;
         latch_r  <= latch_nxt_s;
         oein_d_r <= oeIN;
         for (int i = 0; i < 4; i++) begin
            cnt_r[i] <= cnt_nxt_s[i];
         end
      end
   end

   // Bus drive is combinational on oeIN so a read sees the latch immediately.
   assign data_bus  = oeIN ? latch_r : 4'bzzzz;
   assign BTN_LEVEL = stable_r;
   assign PENDING   = |latch_r;

endmodule
